// File: rtl/amba_apb_req_sched.sv
// Purpose : round-robin arbiter sharing one APB master command port among NREQ requesters.
// Latency : accept -> rsp_valid is 3 cycles minimum (ISSUE, ACCESS, CAPTURE); TIMEOUT cycles max in ISSUE+ACCESS.
// Backpress: one command in flight; req_ready only pulses in IDLE, other requesters hold req_valid and wait.
module amba_apb_req_sched #(
   parameter int NREQ    = 2,
   parameter int ADDR_W  = 8,
   parameter int DATA_W  = 8,
   parameter int TIMEOUT = 16
) (
   input  logic                     pclk,
   input  logic                     preset,
   input  logic [NREQ-1:0]          req_valid,
   input  logic [NREQ-1:0]          req_write,
   input  logic [NREQ*ADDR_W-1:0]   req_addr,
   input  logic [NREQ*DATA_W-1:0]   req_wdata,
   output logic [NREQ-1:0]          req_ready,
   output logic [NREQ-1:0]          rsp_valid,
   output logic [DATA_W-1:0]        rsp_rdata,
   output logic                     rsp_err,
   output logic                     busy,
   output logic                     transfer,
   output logic                     mpwrite,
   output logic [ADDR_W-1:0]        apb_write_paddr,
   output logic [DATA_W-1:0]        apb_write_data,
   output logic [ADDR_W-1:0]        apb_read_paddr,
   input  logic                     psel,
   input  logic                     penable,
   input  logic [DATA_W-1:0]        apb_read_data_out
);

   localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam int CW  = $clog2(TIMEOUT);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_ISSUE   = 2'd1,
      S_ACCESS  = 2'd2,
      S_CAPTURE = 2'd3
   } state_t;

   state_t            r_state;
   state_t            w_next;
   logic [IDW-1:0]    r_last;
   logic [IDW-1:0]    r_id;
   logic              r_write;
   logic [ADDR_W-1:0] r_addr;
   logic [DATA_W-1:0] r_wdata;
   logic              r_err;
   logic [CW-1:0]     r_cnt;

   logic              w_hi_found;
   logic              w_lo_found;
   logic [IDW-1:0]    w_hi;
   logic [IDW-1:0]    w_lo;
   logic              w_found;
   logic [IDW-1:0]    w_win;
   logic              w_tmo;
   logic              w_abort;

   // Counter saturates at TIMEOUT-1, so a late setup handshake still times out in ACCESS.
   assign w_tmo = (r_cnt == CW'(TIMEOUT - 1));

   // Round-robin pick: lowest requester above last_grant, else lowest at or below it.
   always_comb begin
      w_hi_found = 1'b0;
      w_lo_found = 1'b0;
      w_hi       = '0;
      w_lo       = '0;
      for (int i = NREQ - 1; i >= 0; i--) begin
         if (req_valid[i]) begin
            if (IDW'(i) > r_last) begin
               w_hi_found = 1'b1;
               w_hi       = IDW'(i);
            end else begin
               w_lo_found = 1'b1;
               w_lo       = IDW'(i);
            end
         end
      end
      w_found = w_hi_found | w_lo_found;
      w_win   = w_hi_found ? w_hi : w_lo;
   end

   // State register.
   always_ff @(posedge pclk or negedge preset) begin
      if (!preset) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   // Next state; the access handshake takes priority over a coincident timeout.
   always_comb begin
      w_next  = r_state;
      w_abort = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (w_found) w_next = S_ISSUE;
         end
         S_ISSUE: begin
            if (psel && !penable) begin
               w_next = S_ACCESS;
            end else if (w_tmo) begin
               w_next  = S_CAPTURE;
               w_abort = 1'b1;
            end
         end
         S_ACCESS: begin
            if (psel && penable) begin
               w_next = S_CAPTURE;
            end else if (w_tmo) begin
               w_next  = S_CAPTURE;
               w_abort = 1'b1;
            end
         end
         S_CAPTURE: begin
            w_next = S_IDLE;
         end
         default: begin
            w_next = S_IDLE;
         end
      endcase
   end

   // Command latch, round-robin pointer and timeout counter.
   always_ff @(posedge pclk or negedge preset) begin
      if (!preset) begin
         r_last  <= IDW'(NREQ - 1);
         r_id    <= '0;
         r_write <= 1'b0;
         r_addr  <= '0;
         r_wdata <= '0;
         r_err   <= 1'b0;
         r_cnt   <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_found) begin
                  r_last  <= w_win;
                  r_id    <= w_win;
                  r_write <= req_write[w_win];
                  r_addr  <= req_addr[w_win*ADDR_W +: ADDR_W];
                  r_wdata <= req_wdata[w_win*DATA_W +: DATA_W];
                  r_err   <= 1'b0;
                  r_cnt   <= '0;
               end
            end
            S_ISSUE, S_ACCESS: begin
               if (!w_tmo) r_cnt <= r_cnt + CW'(1);
               r_err <= w_abort;
            end
            default: begin
            end
         endcase
      end
   end

   // Output decode from state and latched command; req_ready is forced low while in reset.
   always_comb begin
      req_ready       = '0;
      rsp_valid       = '0;
      rsp_rdata       = '0;
      rsp_err         = 1'b0;
      transfer        = 1'b0;
      mpwrite         = 1'b0;
      apb_write_paddr = '0;
      apb_write_data  = '0;
      apb_read_paddr  = '0;
      busy            = (r_state != S_IDLE);
      case (r_state)
         S_IDLE: begin
            if (w_found && preset) req_ready = NREQ'(1) << w_win;
         end
         S_ISSUE, S_ACCESS: begin
            transfer = 1'b1;
            mpwrite  = r_write;
            if (r_write) begin
               apb_write_paddr = r_addr;
               apb_write_data  = r_wdata;
            end else begin
               apb_read_paddr  = r_addr;
            end
         end
         S_CAPTURE: begin
            rsp_valid = NREQ'(1) << r_id;
            rsp_err   = r_err;
            if (!r_write && !r_err) rsp_rdata = apb_read_data_out;
         end
         default: begin
         end
      endcase
   end

endmodule

// File: doc/amba_apb_req_sched.md
Name: amba_apb_req_sched

Overview:
- Round-robin scheduler sharing the single APB master command port (transfer, mpwrite, write/read address, write data) among NREQ requesters.
- Accepts one command at a time and drives it onto the APB master.
- Tracks the setup/access phases via psel/penable and returns the read data or a timeout error to the requester it accepted.
- Sits between bus-side clients (test sequencers, config engines) and the APB master in the top-level APB subsystem.

Parameters:
NREQ, 2, number of requesters (2..8)
ADDR_W, 8, address width
DATA_W, 8, data width
TIMEOUT, 16, max cycles in ISSUE+ACCESS before abort (>=4)

Ports:
pclk  in  1  clock, rising edge
preset  in  1  reset, asynchronous, active-low
req_valid  in  NREQ  per-requester command pending (level)
req_write  in  NREQ  1=write, 0=read
req_addr  in  NREQ*ADDR_W  packed addresses, requester i at [i*ADDR_W +: ADDR_W]
req_wdata  in  NREQ*DATA_W  packed write data
req_ready  out  NREQ  one-hot, command accepted this cycle
rsp_valid  out  NREQ  one-hot 1-cycle response pulse
rsp_rdata  out  DATA_W  read data, valid with rsp_valid
rsp_err  out  1  timeout flag, valid with rsp_valid
busy  out  1  high when state != IDLE
transfer  out  1  APB transfer request to master
mpwrite  out  1  APB direction
apb_write_paddr  out  ADDR_W  write address
apb_write_data  out  DATA_W  write data
apb_read_paddr  out  ADDR_W  read address
psel  in  1  from master, setup/access select
penable  in  1  from master, access phase
apb_read_data_out  in  DATA_W  read data from master

Behaviour:
- Reset (preset=0, async): state=IDLE, all outputs 0, timeout counter 0, last_grant=NREQ-1 so requester 0 wins first.
- States: IDLE, ISSUE, ACCESS, CAPTURE.
- IDLE:
  - Winner = first asserted req_valid searching last_grant+1 upward, modulo NREQ.
  - req_ready[winner]=1 combinationally in the same cycle.
  - At the edge: latch write/addr/wdata/id, set last_grant=winner, go to ISSUE.
  - No req_valid: stay in IDLE.
- ISSUE:
  - transfer=1, mpwrite=latched write.
  - Write: apb_write_paddr=addr, apb_write_data=wdata, apb_read_paddr=0.
  - Read: apb_read_paddr=addr, apb_write_paddr=0, apb_write_data=0.
  - Go to ACCESS when psel=1 && penable=0 is sampled.
- ACCESS: outputs as in ISSUE. Go to CAPTURE when psel=1 && penable=1 is sampled. psel dropping without penable: keep waiting.
- CAPTURE (1 cycle):
  - transfer=0, mpwrite=0, all address/data outputs 0.
  - rsp_valid[id]=1.
  - rsp_rdata=apb_read_data_out for reads, 0 for writes.
  - rsp_err=0. Next state IDLE.
- Timeout:
  - Counter clears on IDLE->ISSUE and increments every cycle in ISSUE/ACCESS.
  - When the counter reaches TIMEOUT-1 without the access handshake, go to CAPTURE with rsp_err=1, rsp_rdata=0.
- Latency: write with psel in cycle 1 and penable in cycle 2 after ISSUE entry -> rsp_valid 3 cycles after req_ready.
- Minimum spacing between back-to-back accepts: 4 cycles (IDLE, ISSUE, ACCESS, CAPTURE).
- Requester side:
  - req_valid sampled only in IDLE.
  - Deassertion after acceptance has no effect.
  - Requester must hold fields stable only during the accept cycle.
  - Multiple simultaneous req_valid: only the winner gets req_ready; the others wait.
- Round-robin pointer wraps NREQ-1 -> 0. It does not update on cycles without a grant.
- rsp_rdata and rsp_err are zero whenever rsp_valid is all-zero.
- Reset mid-transaction: outputs drop to 0 immediately. No response is issued for the aborted command.

Test Plan:
- Reset: preset=0 while in ACCESS -> transfer=0, rsp_valid=0, busy=0 immediately; after release, req_valid=2'b11 -> req_ready=2'b01 first.
- Single write: requester 0 write addr 0x12 data 0xA5; master psel cycle 1, penable cycle 2 -> apb_write_paddr=0x12, apb_write_data=0xA5, mpwrite=1 until CAPTURE; rsp_valid=2'b01, rsp_err=0, 3 cycles after accept.
- Single read: requester 1 read addr 0x40; apb_read_data_out=0x3C at access -> apb_read_paddr=0x40, mpwrite=0; rsp_valid=2'b10, rsp_rdata=0x3C.
- Fairness: both req_valid held for 4 transactions -> grant order 0,1,0,1; rsp_valid matches each accepted id.
- Timeout: psel held 0, TIMEOUT=16 -> rsp_valid pulse with rsp_err=1, rsp_rdata=0 exactly 16 cycles after entering ISSUE; next request accepted normally.
- Withdraw: requester 0 drops req_valid the cycle after req_ready -> transaction still completes and rsp_valid[0]=1.
